// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one write port, a debug
// read port and a sequential clear engine. Define REG_FILE_BYPASS_EN for write-to-read bypass.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [ADDR_W-1:0] Reg_switch,
  output logic [DATA_W-1:0] Reg_Read,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  clr_state_t        state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              zero_wr;
  logic              wr_ok;

  assign clr_busy = (state == CLEAR);
  assign zero_wr  = (ZERO_REG != 0) && (WriteReg == '0);
  assign wr_ok    = RegWrite && !clr_busy && !zero_wr;

  // Clear engine: walks the pointer over every address, one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      wr_drop  <= RegWrite && clr_busy;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == ADDR_W'(DEPTH - 1)) begin
            state    <= IDLE;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The write port is blocked while busy, so only one writer touches the array per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (clr_busy) begin
      regs[ptr] <= '0;
    end else if (wr_ok) begin
      regs[WriteReg] <= WriteData;
    end
  end

  function automatic logic [DATA_W-1:0] rd_arr(input logic [ADDR_W-1:0] a);
    if ((ZERO_REG != 0) && (a == '0)) begin
      return '0;
    end
    return regs[a];
  endfunction

  assign Reg_Read = rd_arr(Reg_switch);

`ifdef REG_FILE_BYPASS_EN
  // Qualified with rst_n so the read ports stay zero while reset is held.
  logic byp_en;
  assign byp_en     = rst_n && wr_ok;
  assign read_data1 = (byp_en && (ReadRegister1 == WriteReg)) ? WriteData : rd_arr(ReadRegister1);
  assign read_data2 = (byp_en && (ReadRegister2 == WriteReg)) ? WriteData : rd_arr(ReadRegister2);
`else
  assign read_data1 = rd_arr(ReadRegister1);
  assign read_data2 = rd_arr(ReadRegister2);
`endif

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: reset, write/read, bypass, clear engine,
// dropped writes during clear, reset mid-clear and back-to-back clear requests.
module tb_reg_file_param;

  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [4:0]  Reg_switch;
  logic [31:0] Reg_Read;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;
  logic        wr_drop;

  int errors = 0;
  int checks = 0;

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .read_data1(read_data1), .read_data2(read_data2),
    .Reg_switch(Reg_switch), .Reg_Read(Reg_Read),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    RegWrite  = 1'b1;
    WriteReg  = a;
    WriteData = d;
    tick();
    RegWrite  = 1'b0;
  endtask

  task automatic read_all(input logic [4:0] a, output logic [31:0] d1, output logic [31:0] d2,
                          output logic [31:0] dd);
    ReadRegister1 = a;
    ReadRegister2 = a;
    Reg_switch    = a;
    #1;
    d1 = read_data1;
    d2 = read_data2;
    dd = Reg_Read;
  endtask

  task automatic start_clear();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit found);
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      #1;
      if (clr_done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    logic [31:0] d1, d2, dd;
    logic [31:0] exp_byp;
    int busy_cnt, done_cnt;
    bit found;

    rst_n = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0; Reg_switch = '0; clr_req = 1'b0;

    // Reset and all-zero reads
    #3 rst_n = 1'b0;
    tick(); tick();
    read_all(5'd5, d1, d2, dd);
    check("rst_rd1", d1, 32'h0);
    check("rst_busy", {31'b0, clr_busy}, 32'h0);
    check("rst_done", {31'b0, clr_done}, 32'h0);
    check("rst_drop", {31'b0, wr_drop}, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      Reg_switch    = 5'(i);
      #1;
      check($sformatf("init_rd1_r%0d", i), read_data1, 32'h0);
      check($sformatf("init_rd2_r%0d", 31 - i), read_data2, 32'h0);
      check($sformatf("init_dbg_r%0d", i), Reg_Read, 32'h0);
    end
    tick();

    // Write/read, r0 hard-wired
    do_write(5'd5, 32'hDEADBEEF);
    do_write(5'd0, 32'h12345678);
    read_all(5'd5, d1, d2, dd);
    check("wr_r5_rd1", d1, 32'hDEADBEEF);
    check("wr_r5_rd2", d2, 32'hDEADBEEF);
    check("wr_r5_dbg", dd, 32'hDEADBEEF);
    read_all(5'd0, d1, d2, dd);
    check("wr_r0_rd1", d1, 32'h0);
    check("wr_r0_dbg", dd, 32'h0);
    tick();

    // Same-cycle bypass on r7; debug port never bypassed
`ifdef REG_FILE_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = 32'h0;
`endif
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'hA5A5A5A5;
    read_all(5'd7, d1, d2, dd);
    check("byp_rd1", d1, exp_byp);
    check("byp_rd2", d2, exp_byp);
    check("byp_dbg", dd, 32'h0);
    tick();
    RegWrite = 1'b0;
    read_all(5'd7, d1, d2, dd);
    check("post_byp_rd1", d1, 32'hA5A5A5A5);
    check("post_byp_dbg", dd, 32'hA5A5A5A5);
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF;
    read_all(5'd0, d1, d2, dd);
    check("byp_r0_rd1", d1, 32'h0);
    tick();
    RegWrite = 1'b0;

    // Fill r1..r31, then a full clear
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'hC0000000 + 32'(i));
    read_all(5'd31, d1, d2, dd);
    check("fill_r31", d1, 32'hC000001F);
    read_all(5'd1, d1, d2, dd);
    check("fill_r1", d2, 32'hC0000001);
    tick();
    start_clear();
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 45; k++) begin
      #1;
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      tick();
    end
    check("clr_busy_cycles", 32'(busy_cnt), 32'd32);
    check("clr_done_pulses", 32'(done_cnt), 32'd1);
    for (int i = 0; i < 32; i++) begin
      read_all(5'(i), d1, d2, dd);
      check($sformatf("clr_r%0d", i), d1 | d2 | dd, 32'h0);
    end
    tick();

    // Writes during clear are dropped
    do_write(5'd3, 32'h00000033);
    do_write(5'd1, 32'h00000011);
    do_write(5'd20, 32'h00002020);
    start_clear();
    #1 check("wdc_busy", {31'b0, clr_busy}, 32'h1);
    tick(); tick();
    read_all(5'd20, d1, d2, dd);
    check("wdc_partial_r20", d1, 32'h00002020);
    read_all(5'd1, d1, d2, dd);
    check("wdc_partial_r1", d1, 32'h0);
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h00005555;
    check("wdc_drop_before", {31'b0, wr_drop}, 32'h0);
    tick();
    RegWrite = 1'b1; WriteReg = 5'd1; WriteData = 32'h00001111;
    #1 check("wdc_drop1", {31'b0, wr_drop}, 32'h1);
    tick();
    RegWrite = 1'b0;
    read_all(5'd1, d1, d2, dd);
    check("wdc_drop2", {31'b0, wr_drop}, 32'h1);
    check("wdc_r1_kept_zero", d1, 32'h0);
    tick();
    #1 check("wdc_drop_after", {31'b0, wr_drop}, 32'h0);
    wait_done(60, found);
    check("wdc_done_seen", {31'b0, found}, 32'h1);
    read_all(5'd3, d1, d2, dd);
    check("wdc_r3", d1, 32'h0);
    read_all(5'd1, d1, d2, dd);
    check("wdc_r1", d1, 32'h0);
    read_all(5'd20, d1, d2, dd);
    check("wdc_r20", d1, 32'h0);
    tick();

    // Reset 10 cycles into a clear aborts it
    do_write(5'd31, 32'hFFFF0000);
    do_write(5'd9, 32'h00000099);
    start_clear();
    repeat (10) tick();
    ReadRegister1 = 5'd31; ReadRegister2 = 5'd9; Reg_switch = 5'd31;
    #2 rst_n = 1'b0;
    #1;
    check("rmc_busy", {31'b0, clr_busy}, 32'h0);
    check("rmc_r31", read_data1, 32'h0);
    check("rmc_r9", read_data2, 32'h0);
    check("rmc_dbg", Reg_Read, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      tick();
    end
    check("rmc_no_busy", 32'(busy_cnt), 32'd0);
    check("rmc_no_done", 32'(done_cnt), 32'd0);

    // clr_req held through clr_done restarts the clear on the next edge
    clr_req = 1'b1;
    tick();
    wait_done(60, found);
    check("hold_done1", {31'b0, found}, 32'h1);
    check("hold_busy_low_at_done", {31'b0, clr_busy}, 32'h0);
    tick();
    #1 check("hold_restart_busy", {31'b0, clr_busy}, 32'h1);
    clr_req = 1'b0;
    wait_done(60, found);
    check("hold_done2", {31'b0, found}, 32'h1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
